// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: two producers (load has priority over ALU) feed an in-order FIFO
// that drains one entry per cycle and forwards the youngest pending data. Optional feature: WB_COALESCE_EN.
module rf_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic              Fwd1_hit,
  output logic [DATA_W-1:0] Fwd1_data,
  output logic              Fwd2_hit,
  output logic [DATA_W-1:0] Fwd2_data,
  output logic [CNT_W-1:0]  Pending
);

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              full;
  logic              empty;
  logic              mem_take;
  logic              alu_take;
  logic              enq;
  logic              deq;
  logic              coalesce;
  logic              push;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Readies ignore a same-cycle dequeue: a full queue never accepts.
  assign mem_ready = !full && !reset;
  assign alu_ready = !full && !mem_valid && !reset;

  assign mem_take = mem_valid && mem_ready;
  assign alu_take = alu_valid && alu_ready;
  assign enq      = mem_take || alu_take;
  assign in_reg   = mem_take ? mem_reg  : alu_reg;
  assign in_data  = mem_take ? mem_data : alu_data;
  assign deq      = !empty && !reset;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] last_ptr;

  assign last_ptr = tail_reg - PTR_W'(1);
  // count >= 2 keeps the head entry (being written to the RF now) out of reach.
  assign coalesce = enq && (count_reg >= CNT_W'(2)) && (reg_mem[last_ptr] == in_reg);
`else
  assign coalesce = 1'b0;
`endif

  assign push = enq && !coalesce;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (deq) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      case ({push, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; occupancy is defined solely by head/count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push) begin
        reg_mem[tail_reg]  <= in_reg;
        data_mem[tail_reg] <= in_data;
      end
`ifdef WB_COALESCE_EN
      else if (coalesce) begin
        data_mem[last_ptr] <= in_data;
      end
`endif
    end
  end

  assign RegWrite  = deq;
  assign WriteReg  = deq ? reg_mem[head_reg]  : '0;
  assign WriteData = deq ? data_mem[head_reg] : '0;
  assign Pending   = reset ? '0 : count_reg;

  logic [ADDR_W-1:0] rd_addr [2];

  assign rd_addr[0] = Read1;
  assign rd_addr[1] = Read2;

  // Walk entries oldest to youngest so the last match wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  idx;

    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (!reset) begin
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_reg + PTR_W'(k);
          if ((CNT_W'(k) < count_reg) && (reg_mem[idx] == rd_addr[gi])) begin
            hit  = 1'b1;
            data = data_mem[idx];
          end
        end
      end
    end
  end

  assign Fwd1_hit  = g_fwd[0].hit;
  assign Fwd1_data = g_fwd[0].data;
  assign Fwd2_hit  = g_fwd[1].hit;
  assign Fwd2_data = g_fwd[1].data;

endmodule
